// File: rtl/ahb_lite_bus_ctrl_pkg.sv
// Shared types for the single-master AHB-Lite bus controller: transfer type,
// response, data-phase slave select and default-slave FSM state.
package ahb_lite_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } hresp_t;

  typedef enum logic [1:0] {
    SEL_S0  = 2'd0,
    SEL_S1  = 2'd1,
    SEL_DEF = 2'd2
  } slv_sel_t;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } def_state_t;

  // Only NONSEQ/SEQ carry a real transfer; IDLE/BUSY must get a zero-wait OKAY.
  function automatic logic is_active(input htrans_t t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_lite_default_slave.sv
// Built-in default slave: answers unmapped NONSEQ/SEQ transfers with the
// two-cycle AHB ERROR response (HREADYOUT 0/1, HRESP 1/1).
module ahb_lite_default_slave
  import ahb_lite_defs::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_hready,
  input  logic i_req,
  output logic o_hreadyout,
  output logic o_hresp
);

  def_state_t r_state;
  logic       r_hreadyout;
  hresp_t     r_hresp;

  // NOTE: state and registered outputs use non-blocking assignments so every
  // reader sees the pre-edge value; blocking here would race other flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= DS_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= OKAY;
    end else begin
      unique case (r_state)
        DS_IDLE: begin
          if (i_hready && i_req) begin
            r_state     <= DS_ERR1;
            r_hreadyout <= 1'b0;
            r_hresp     <= ERROR;
          end
        end
        DS_ERR1: begin
          r_state     <= DS_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= ERROR;
        end
        DS_ERR2: begin
          // A new unmapped address phase completes in ERR2, so chain straight on.
          if (i_hready && i_req) begin
            r_state     <= DS_ERR1;
            r_hreadyout <= 1'b0;
            r_hresp     <= ERROR;
          end else begin
            r_state     <= DS_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= OKAY;
          end
        end
        default: begin
          r_state     <= DS_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= OKAY;
        end
      endcase
    end
  end

  assign o_hreadyout = r_hreadyout;
  assign o_hresp     = r_hresp;

endmodule

// File: rtl/ahb_lite_bus_ctrl.sv
// Single-master AHB-Lite bus controller: address decode, data-phase response
// mux, built-in default slave and a sticky stall watchdog.
module ahb_lite_bus_ctrl
  import ahb_lite_defs::*;
#(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 32,
  parameter logic [ADDR_W-1:0] S0_BASE = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] S0_MASK = 32'hFFFF_F000,
  parameter logic [ADDR_W-1:0] S1_BASE = 32'h0000_1000,
  parameter logic [ADDR_W-1:0] S1_MASK = 32'hFFFF_F000,
  parameter int                TIMEOUT = 256
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  output logic              HSEL0,
  output logic              HSEL1,
  input  logic [DATA_W-1:0] HRDATA0,
  input  logic              HREADYOUT0,
  input  logic              HRESP0,
  input  logic [DATA_W-1:0] HRDATA1,
  input  logic              HREADYOUT1,
  input  logic              HRESP1,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADY,
  output logic              HRESP,
  output logic              stall_err,
  input  logic              stall_clr
);

  localparam int                CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT);

  slv_sel_t         w_dec_sel;
  slv_sel_t         r_data_sel;
  logic             w_def_req;
  logic             w_def_hreadyout;
  logic             w_def_hresp;
  logic             w_stall_set;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_stall_err;

  // NOTE: every combinational output gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    w_dec_sel = SEL_DEF;
    if ((HADDR & S0_MASK) == S0_BASE) begin
      w_dec_sel = SEL_S0;
    end else if ((HADDR & S1_MASK) == S1_BASE) begin
      w_dec_sel = SEL_S1;
    end
  end

  assign HSEL0     = (w_dec_sel == SEL_S0);
  assign HSEL1     = (w_dec_sel == SEL_S1);
  assign w_def_req = (w_dec_sel == SEL_DEF) && is_active(htrans_t'(HTRANS));

  // Data-phase owner advances only when the current data phase completes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_data_sel <= SEL_DEF;
    end else if (HREADY) begin
      r_data_sel <= w_dec_sel;
    end
  end

  ahb_lite_default_slave u_def_slave (
    .clk         (HCLK),
    .rst_n       (HRESETn),
    .i_hready    (HREADY),
    .i_req       (w_def_req),
    .o_hreadyout (w_def_hreadyout),
    .o_hresp     (w_def_hresp)
  );

  always_comb begin
    HRDATA = '0;
    HREADY = w_def_hreadyout;
    HRESP  = w_def_hresp;
    unique case (r_data_sel)
      SEL_S0: begin
        HRDATA = HRDATA0;
        HREADY = HREADYOUT0;
        HRESP  = HRESP0;
      end
      SEL_S1: begin
        HRDATA = HRDATA1;
        HREADY = HREADYOUT1;
        HRESP  = HRESP1;
      end
      default: ;
    endcase
  end

  // The wait cycle that brings the count to TIMEOUT is the one that flags the stall.
  assign w_stall_set = !HREADY && (r_wait_cnt >= TO_MAX - 1'b1);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wait_cnt  <= '0;
      r_stall_err <= 1'b0;
    end else begin
      if (HREADY) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != TO_MAX) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_stall_set) begin
        r_stall_err <= 1'b1;
      end else if (stall_clr) begin
        r_stall_err <= 1'b0;
      end
    end
  end

  assign stall_err = r_stall_err;

endmodule

// File: tb/tb_ahb_lite_bus_ctrl.sv
// Directed bench for ahb_lite_bus_ctrl: expected data-phase results are queued
// when an address phase is accepted and popped when the data phase completes.
module tb_ahb_lite_bus_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic        resp;
  } exp_t;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HSEL0, HSEL1;
  logic [31:0] HRDATA0, HRDATA1, HRDATA;
  logic        HREADYOUT0, HREADYOUT1, HRESP0, HRESP1;
  logic        HREADY, HRESP, stall_err, stall_clr;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  always #5 HCLK = ~HCLK;

  ahb_lite_bus_ctrl dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HSEL0      (HSEL0),
    .HSEL1      (HSEL1),
    .HRDATA0    (HRDATA0),
    .HREADYOUT0 (HREADYOUT0),
    .HRESP0     (HRESP0),
    .HRDATA1    (HRDATA1),
    .HREADYOUT1 (HREADYOUT1),
    .HRESP1     (HRESP1),
    .HRDATA     (HRDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .stall_err  (stall_err),
    .stall_clr  (stall_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic push(input logic [31:0] rdata, input logic resp);
    exp_t e;
    e.rdata = rdata;
    e.resp  = resp;
    sb.push_back(e);
  endtask

  // Called at the sample point of a cycle where a data phase should complete.
  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: got empty scoreboard want queued entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_hready"}, 32'(HREADY), 32'd1);
      chk({tag, "_hresp"},  32'(HRESP),  32'(e.resp));
      chk({tag, "_hrdata"}, HRDATA,      e.rdata);
    end
  endtask

  initial begin
    HRESETn    = 1'b0;
    HADDR      = 32'h0;
    HTRANS     = T_IDLE;
    HRDATA0    = 32'h0BAD_0000;
    HRDATA1    = 32'h0;
    HREADYOUT0 = 1'b1;
    HREADYOUT1 = 1'b1;
    HRESP0     = 1'b0;
    HRESP1     = 1'b0;
    stall_clr  = 1'b0;

    // Reset values: default slave owns the data phase, so HRDATA is 0.
    @(negedge HCLK);
    chk("rst_hready", 32'(HREADY),    32'd1);
    chk("rst_hresp",  32'(HRESP),     32'd0);
    chk("rst_hrdata", HRDATA,         32'h0);
    chk("rst_stall",  32'(stall_err), 32'd0);

    // 1. Idle cycles at HADDR=0.
    tick();
    HRESETn = 1'b1;
    HRDATA0 = 32'h0;
    tick();
    tick();
    @(negedge HCLK);
    chk("idle_hsel0",  32'(HSEL0),     32'd1);
    chk("idle_hsel1",  32'(HSEL1),     32'd0);
    chk("idle_hready", 32'(HREADY),    32'd1);
    chk("idle_hresp",  32'(HRESP),     32'd0);
    chk("idle_hrdata", HRDATA,         32'h0);
    chk("idle_stall",  32'(stall_err), 32'd0);

    // 2. Zero-wait read from slave0.
    tick();
    HADDR  = 32'h0000_0010;
    HTRANS = T_NONSEQ;
    @(negedge HCLK);
    chk("s0_hsel0", 32'(HSEL0), 32'd1);
    push(32'hDEAD_BEEF, 1'b0);
    tick();
    HTRANS  = T_IDLE;
    HADDR   = 32'h0;
    HRDATA0 = 32'hDEAD_BEEF;
    @(negedge HCLK);
    pop_cmp("s0_read");

    // 3. Slave1 inserts three wait states; the next address is held meanwhile.
    tick();
    HADDR   = 32'h0000_1004;
    HTRANS  = T_NONSEQ;
    HRDATA1 = 32'h1111_1111;
    @(negedge HCLK);
    chk("s1_hsel1", 32'(HSEL1), 32'd1);
    chk("s1_hsel0", 32'(HSEL0), 32'd0);
    push(32'hCAFE_0001, 1'b0);
    tick();
    HREADYOUT1 = 1'b0;
    HADDR      = 32'h0000_0020;
    HRDATA0    = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk($sformatf("s1_wait%0d_hready", i), 32'(HREADY), 32'd0);
      chk($sformatf("s1_wait%0d_hrdata", i), HRDATA,      32'h1111_1111);
      tick();
    end
    HREADYOUT1 = 1'b1;
    HRDATA1    = 32'hCAFE_0001;
    @(negedge HCLK);
    pop_cmp("s1_read");
    chk("held_hsel0", 32'(HSEL0), 32'd1);
    push(32'h2222_2222, 1'b0);
    tick();
    HTRANS  = T_IDLE;
    HADDR   = 32'h0000_1000;
    HRDATA0 = 32'h2222_2222;
    @(negedge HCLK);
    pop_cmp("s0_after_s1");

    // 4. Two back-to-back unmapped transfers: ERR1,ERR2,ERR1,ERR2, then OKAY.
    tick();
    HADDR  = 32'h8000_0000;
    HTRANS = T_NONSEQ;
    @(negedge HCLK);
    chk("um_hsel0", 32'(HSEL0), 32'd0);
    chk("um_hsel1", 32'(HSEL1), 32'd0);
    push(32'h0, 1'b1);
    tick();
    @(negedge HCLK);
    chk("um1_err1_hready", 32'(HREADY), 32'd0);
    chk("um1_err1_hresp",  32'(HRESP),  32'd1);
    tick();
    @(negedge HCLK);
    pop_cmp("um1_err2");
    push(32'h0, 1'b1);
    tick();
    HTRANS = T_IDLE;
    HADDR  = 32'h0;
    @(negedge HCLK);
    chk("um2_err1_hready", 32'(HREADY), 32'd0);
    chk("um2_err1_hresp",  32'(HRESP),  32'd1);
    tick();
    @(negedge HCLK);
    pop_cmp("um2_err2");
    tick();
    @(negedge HCLK);
    chk("um_after_hready", 32'(HREADY), 32'd1);
    chk("um_after_hresp",  32'(HRESP),  32'd0);

    // 5. Unmapped, then slave0: slave0 address phase completes in ERR2.
    tick();
    HADDR  = 32'h9000_0000;
    HTRANS = T_NONSEQ;
    @(negedge HCLK);
    push(32'h0, 1'b1);
    tick();
    HADDR = 32'h0000_0040;
    @(negedge HCLK);
    chk("mix_err1_hready", 32'(HREADY), 32'd0);
    chk("mix_err1_hresp",  32'(HRESP),  32'd1);
    chk("mix_err1_hsel0",  32'(HSEL0),  32'd1);
    tick();
    @(negedge HCLK);
    pop_cmp("mix_err2");
    push(32'h4444_4444, 1'b0);
    tick();
    HTRANS  = T_IDLE;
    HADDR   = 32'h0;
    HRDATA0 = 32'h4444_4444;
    @(negedge HCLK);
    pop_cmp("mix_s0");

    // IDLE to an unmapped address gets a zero-wait OKAY.
    tick();
    HADDR = 32'hF000_0000;
    tick();
    @(negedge HCLK);
    chk("um_idle_hready", 32'(HREADY), 32'd1);
    chk("um_idle_hresp",  32'(HRESP),  32'd0);
    chk("um_idle_hrdata", HRDATA,      32'h0);

    // 6. Slave0 stalls: stall_err rises on the 256th wait cycle, bus untouched.
    tick();
    HADDR  = 32'h0;
    HTRANS = T_NONSEQ;
    push(32'h5555_5555, 1'b0);
    tick();
    HTRANS     = T_IDLE;
    HREADYOUT0 = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      @(negedge HCLK);
      if (k == 255) chk("stall_255", 32'(stall_err), 32'd0);
      if (k == 256) begin
        chk("stall_256",        32'(stall_err), 32'd1);
        chk("stall_256_hready", 32'(HREADY),    32'd0);
      end
    end
    tick();
    HREADYOUT0 = 1'b1;
    HRDATA0    = 32'h5555_5555;
    @(negedge HCLK);
    pop_cmp("stall_done");
    chk("stall_sticky", 32'(stall_err), 32'd1);
    tick();
    stall_clr = 1'b1;
    @(negedge HCLK);
    chk("stall_clr_pending", 32'(stall_err), 32'd1);
    tick();
    stall_clr = 1'b0;
    @(negedge HCLK);
    chk("stall_cleared", 32'(stall_err), 32'd0);

    // Async reset during ERR1 abandons the transfer at once.
    tick();
    HADDR  = 32'hA000_0000;
    HTRANS = T_NONSEQ;
    tick();
    HTRANS = T_IDLE;
    HADDR  = 32'h0;
    @(negedge HCLK);
    chk("rstmid_err1_hready", 32'(HREADY), 32'd0);
    #1;
    HRESETn = 1'b0;
    #1;
    chk("rstmid_hready", 32'(HREADY), 32'd1);
    chk("rstmid_hresp",  32'(HRESP),  32'd0);
    chk("rstmid_hrdata", HRDATA,      32'h0);
    tick();
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rstmid_after_hready", 32'(HREADY), 32'd1);
    chk("rstmid_after_hresp",  32'(HRESP),  32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
